vec_seq_ctrl: RTL and testbench
===============================

# vec_seq_ctrl

Multi-cycle sequencer for the vector datapath. It sits between ID and the vector ALU/memory banks. It accepts one instruction at a time over a valid/ready handshake and maintains the index registers i, j and length n. It expands SUMFV/MULFV into n element cycles of read/write enables and addresses, which the single-cycle control decode cannot express.

## Interface
- ADDR_W, 8, width of element addresses and of i/j
- N_W, 8, width of vector length n and of immediate
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept
- opcode  in  4  0000 INCRI, 0001 INCRJ, 0010 SETN, 0011 SUMFV, 0100 MULFV, 0101 NOP, others reserved
- imm  in  N_W  immediate for INCRI/INCRJ/SETN
- rd_addr  out  ADDR_W  element read address
- wr_addr  out  ADDR_W  element write address
- vec_alu_op  out  1  0 add (SUMFV), 1 multiply (MULFV)
- r_mem_1, r_mem_2  out  1 each  read enables, banks 1/2
- w_mem_2, w_mem_3  out  1 each  write enables, banks 2/3
- busy  out  1  vector op in progress
- done  out  1  one-cycle pulse at vector op completion
- i_idx, j_idx  out  ADDR_W  current i, j
- n_len  out  N_W  current n

## Operation
- States: IDLE, RUN, DRAIN. instr_ready = (state==IDLE), combinational; busy = !IDLE.
- Accept = instr_valid && instr_ready, sampled at rising edge.
- INCRI: i <= i + imm; INCRJ: j <= j + imm. Both are mod 2^ADDR_W, imm zero-extended or truncated to ADDR_W. SETN: n <= imm. NOP/reserved: no state change. All stay in IDLE.
- SUMFV: read bank 2 at i+k, write bank 3 at j+k, vec_alu_op=0. MULFV: read bank 1 at i+k, write bank 2 at j+k, vec_alu_op=1. k = 0..n-1.
- Opcode class, i, j, n latched at accept; changes to inputs during busy are ignored.
- IDLE -> RUN on vector accept with n>0; IDLE -> DRAIN on vector accept with n==0.
- RUN, element counter k: read enable on, rd_addr=i+k. Write enable on for element k-1 when k>0, wr_addr=j+k-1. RUN -> DRAIN after k==n-1.
- DRAIN: write element n-1 (suppressed if n==0), done=1, then -> IDLE.
- Address sums wrap mod 2^ADDR_W.
- vec_alu_op holds last vector op value; 0 after reset. All enables 0 outside RUN/DRAIN.

## Timing
- Scalar op: register visible on i_idx/j_idx/n_len the cycle after accept; throughput one per cycle.
- Vector op, n>0: first read in the cycle after accept. ALU latency is 1: write for element k occurs one cycle after its read. Busy for exactly n+1 cycles; done coincides with last write.
- Vector op, n==0: busy 1 cycle, done=1, no enables.
- Next instruction is accepted in the cycle after done.
- Reset, including mid-operation: state IDLE; i=j=n=0, k=0. All enables, done, busy, vec_alu_op, addresses 0; instr_ready=1. No further enables after rst rises.

## Configuration
- VSEQ_AUTOINC_EN defined: on vector completion (DRAIN edge), i <= i+n and j <= j+n, mod 2^ADDR_W. This lets back-to-back vector ops stream over consecutive chunks.
- Undefined: i and j change only via INCRI/INCRJ/reset.

## Test plan
- Reset, then SETN 4, INCRI 2, INCRJ 10 -> n_len=4, i_idx=2, j_idx=10 on consecutive cycles; instr_ready held 1.
- SUMFV with i=2, j=10, n=4 -> r_mem_2 cycles 1-4 with rd_addr 2,3,4,5; w_mem_3 cycles 2-5 with wr_addr 10,11,12,13; done at cycle 5; no r_mem_1/w_mem_2.
- MULFV, n=0 -> busy and done for 1 cycle, no enables, vec_alu_op=1.
- i=254, n=3, MULFV -> rd_addr 254,255,0; instr_valid held high during busy -> not accepted until done+1.
- rst asserted mid-SUMFV at element 2 -> all outputs 0 asynchronously, no further enables, ready=1.
- With VSEQ_AUTOINC_EN, i=0, j=0, n=4, two SUMFV -> second reads 4..7 and writes 4..7. Without the macro -> second reads 0..3.

Source files
------------

// File: rtl/vec_seq_ctrl_if.sv
// rtl/vec_seq_ctrl_if.sv - instruction handshake channel into the vector sequencer
interface vec_seq_ctrl_if #(
  parameter int N_W = 8
);
  logic           instr_valid;
  logic           instr_ready;
  logic [3:0]     opcode;
  logic [N_W-1:0] imm;

  modport master (output instr_valid, output opcode, output imm, input instr_ready);
  modport slave  (input instr_valid, input opcode, input imm, output instr_ready);
endinterface

// File: rtl/vec_seq_ctrl.sv
// rtl/vec_seq_ctrl.sv - multi-cycle vector sequencer (optional VSEQ_AUTOINC_EN: advance i/j by n after each vector op)
module vec_seq_ctrl #(
  parameter int ADDR_W = 8,
  parameter int N_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  vec_seq_ctrl_if.slave     instr,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              vec_alu_op_o,
  output logic              r_mem_1_o,
  output logic              r_mem_2_o,
  output logic              w_mem_2_o,
  output logic              w_mem_3_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] i_idx_o,
  output logic [ADDR_W-1:0] j_idx_o,
  output logic [N_W-1:0]    n_len_o
);

  localparam logic [3:0] OP_INCRI = 4'b0000;
  localparam logic [3:0] OP_INCRJ = 4'b0001;
  localparam logic [3:0] OP_SETN  = 4'b0010;
  localparam logic [3:0] OP_SUMFV = 4'b0011;
  localparam logic [3:0] OP_MULFV = 4'b0100;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] i_q, j_q;
  logic [N_W-1:0]    n_q;
  logic [N_W-1:0]    k_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic              rd_en_q, wr_en_q, mul_q, done_q;

  logic              accept;
  logic [N_W-1:0]    k_d;
  logic              last_elem;

  assign instr.instr_ready = (state_q == IDLE);
  assign accept            = instr.instr_valid && (state_q == IDLE);
  assign k_d               = k_q + N_W'(1);
  assign last_elem         = (k_q == n_q - N_W'(1));

  // Sequencer FSM: scalar index updates in IDLE, element streaming in RUN, final write + done in DRAIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      n_q       <= '0;
      k_q       <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      mul_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
          if (accept) begin
            case (instr.opcode)
              OP_INCRI: i_q <= i_q + ADDR_W'(instr.imm);
              OP_INCRJ: j_q <= j_q + ADDR_W'(instr.imm);
              OP_SETN:  n_q <= instr.imm;
              OP_SUMFV, OP_MULFV: begin
                mul_q     <= (instr.opcode == OP_MULFV);
                k_q       <= '0;
                rd_addr_q <= i_q;
                if (n_q != '0) begin
                  state_q <= RUN;
                  rd_en_q <= 1'b1;
                end else begin
                  // empty vector: one DRAIN cycle with done and no enables
                  state_q <= DRAIN;
                  done_q  <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          // the ALU result for the element just read is written one cycle later
          wr_en_q   <= 1'b1;
          wr_addr_q <= j_q + ADDR_W'(k_q);
          if (last_elem) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            k_q       <= k_d;
            rd_addr_q <= i_q + ADDR_W'(k_d);
          end
        end
        DRAIN: begin
          state_q   <= IDLE;
          rd_en_q   <= 1'b0;
          wr_en_q   <= 1'b0;
          k_q       <= '0;
          rd_addr_q <= '0;
          wr_addr_q <= '0;
`ifdef VSEQ_AUTOINC_EN
          i_q <= i_q + ADDR_W'(n_q);
          j_q <= j_q + ADDR_W'(n_q);
`else
          i_q <= i_q;
          j_q <= j_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_addr_o    = rd_addr_q;
  assign wr_addr_o    = wr_addr_q;
  assign vec_alu_op_o = mul_q;
  assign r_mem_1_o    = rd_en_q & mul_q;
  assign r_mem_2_o    = rd_en_q & ~mul_q;
  assign w_mem_2_o    = wr_en_q & mul_q;
  assign w_mem_3_o    = wr_en_q & ~mul_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign i_idx_o      = i_q;
  assign j_idx_o      = j_q;
  assign n_len_o      = n_q;

endmodule

// File: tb/tb_vec_seq_ctrl.sv
// tb/tb_vec_seq_ctrl.sv - directed and randomized bench for vec_seq_ctrl against a behavioural model
module tb_vec_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rd_addr, wr_addr, i_idx, j_idx, n_len;
  logic       vec_alu_op, r_mem_1, r_mem_2, w_mem_2, w_mem_3, busy, done;

  vec_seq_ctrl_if #(.N_W(8)) bus ();

  vec_seq_ctrl #(.ADDR_W(8), .N_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (bus),
    .rd_addr_o    (rd_addr),
    .wr_addr_o    (wr_addr),
    .vec_alu_op_o (vec_alu_op),
    .r_mem_1_o    (r_mem_1),
    .r_mem_2_o    (r_mem_2),
    .w_mem_2_o    (w_mem_2),
    .w_mem_3_o    (w_mem_3),
    .busy_o       (busy),
    .done_o       (done),
    .i_idx_o      (i_idx),
    .j_idx_o      (j_idx),
    .n_len_o      (n_len)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference state: plain integers updated from the instruction-level rules
  int i_m = 0, j_m = 0, n_m = 0;
  int mul_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},  32'(busy), 0);
    chk({tag, ".ready"}, 32'(bus.instr_ready), 1);
    chk({tag, ".done"},  32'(done), 0);
    chk({tag, ".en"},    32'({r_mem_1, r_mem_2, w_mem_2, w_mem_3}), 0);
    chk({tag, ".i"},     32'(i_idx), 32'(i_m));
    chk({tag, ".j"},     32'(j_idx), 32'(j_m));
    chk({tag, ".n"},     32'(n_len), 32'(n_m));
    chk({tag, ".aluop"}, 32'(vec_alu_op), 32'(mul_m));
  endtask

  // one scalar instruction; leaves valid high so back-to-back calls are consecutive cycles
  task automatic scalar(input int op, input int imm);
    bus.instr_valid = 1'b1;
    bus.opcode      = 4'(op);
    bus.imm         = 8'(imm);
    chk("scalar.ready_pre", 32'(bus.instr_ready), 1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    if (op == 0) i_m = (i_m + imm) % 256;
    if (op == 1) j_m = (j_m + imm) % 256;
    if (op == 2) n_m = imm % 256;
    chk_idle("scalar");
  endtask

  // one vector instruction; with hold, valid stays high with SETN 7 during busy
  task automatic vec(input int op, input int hold);
    int i0, j0, n0, m, er, ew, ed;
    i0 = i_m; j0 = j_m; n0 = n_m;
    m  = (op == 4) ? 1 : 0;
    mul_m = m;
    bus.instr_valid = 1'b1;
    bus.opcode      = 4'(op);
    bus.imm         = 8'($urandom);
    for (int c = 1; c <= n0 + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold != 0) begin
          bus.opcode = 4'd2;
          bus.imm    = 8'd7;
        end else begin
          bus.instr_valid = 1'b0;
        end
      end
      er = (c <= n0) ? 1 : 0;
      ew = (c >= 2) ? 1 : 0;
      ed = (c == n0 + 1) ? 1 : 0;
      chk("vec.r_mem_1", 32'(r_mem_1), 32'(er & m));
      chk("vec.r_mem_2", 32'(r_mem_2), 32'(er & ~m & 1));
      chk("vec.w_mem_2", 32'(w_mem_2), 32'(ew & m));
      chk("vec.w_mem_3", 32'(w_mem_3), 32'(ew & ~m & 1));
      chk("vec.busy",    32'(busy), 1);
      chk("vec.ready",   32'(bus.instr_ready), 0);
      chk("vec.done",    32'(done), 32'(ed));
      chk("vec.aluop",   32'(vec_alu_op), 32'(m));
      chk("vec.n_hold",  32'(n_len), 32'(n0));
      if (er != 0) chk("vec.rd_addr", 32'(rd_addr), 32'((i0 + c - 1) % 256));
      if (ew != 0) chk("vec.wr_addr", 32'(wr_addr), 32'((j0 + c - 2) % 256));
    end
`ifdef VSEQ_AUTOINC_EN
    i_m = (i_m + n0) % 256;
    j_m = (j_m + n0) % 256;
`endif
    @(negedge clk);
    chk_idle("vec.after");
    if (hold != 0) begin
      @(negedge clk);
      bus.instr_valid = 1'b0;
      n_m = 7;
      chk_idle("vec.held_accept");
    end
  endtask

  initial begin
    int op, delta;
    bus.instr_valid = 1'b0;
    bus.opcode      = 4'd5;
    bus.imm         = 8'd0;

    // reset state
    @(negedge clk);
    chk("rst.rd_addr", 32'(rd_addr), 0);
    chk("rst.wr_addr", 32'(wr_addr), 0);
    chk_idle("rst");
    rst = 1'b0;
    @(negedge clk);

    // scalar updates on consecutive cycles
    scalar(2, 4);
    scalar(0, 2);
    scalar(1, 10);

    // SUMFV i=2 j=10 n=4
    vec(3, 0);

    // MULFV with n=0
    scalar(2, 0);
    vec(4, 0);

    // wrap-around: i=254, n=3, valid held during busy
    delta = (254 - i_m + 256) % 256;
    scalar(0, delta);
    scalar(2, 3);
    vec(4, 1);

    // asynchronous reset in the middle of a SUMFV, while element 2 is being read
    scalar(2, 4);
    bus.instr_valid = 1'b1;
    bus.opcode      = 4'd3;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst.r_mem_2_pre", 32'(r_mem_2), 1);
    #2 rst = 1'b1;
    #1;
    i_m = 0; j_m = 0; n_m = 0; mul_m = 0;
    chk("midrst.rd_addr", 32'(rd_addr), 0);
    chk("midrst.wr_addr", 32'(wr_addr), 0);
    chk_idle("midrst");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("midrst.en_hold", 32'({r_mem_1, r_mem_2, w_mem_2, w_mem_3, done, busy}), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk_idle("midrst.release");

    // back-to-back SUMFV over n=4 from i=j=0
    scalar(2, 4);
    vec(3, 0);
    vec(3, 0);

    // randomized instruction stream
    for (int t = 0; t < 40; t++) begin
      op = int'($urandom_range(0, 15));
      if (op == 2)                 scalar(2, int'($urandom_range(0, 6)));
      else if (op == 3 || op == 4) vec(op, int'($urandom_range(0, 1)));
      else                         scalar(op, int'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
